cla_checker: RTL and testbench
==============================

CLA_CHECKER -- requirements
Module: cla_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width; sum width is WIDTH+1.
REQ-002 SHALL have parameter CNT_W, default 16: width of the pass and fail counters.
REQ-003 SHALL have parameter HALT_ON_FAIL, default 1: when 1, the first mismatch stops acceptance.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: sample {a,b,sum} is presented.
REQ-007 SHALL have port in_ready, output, 1: checker can accept a sample.
REQ-008 SHALL have ports a and b, input, WIDTH each: operands applied to the adder under test.
REQ-009 SHALL have port sum, input, WIDTH+1: adder result, carry in the MSB.
REQ-010 SHALL have port clear, input, 1: clears counters and flags, and leaves HALT.
REQ-011 SHALL have ports pass_cnt and fail_cnt, output, CNT_W each: saturating counts.
REQ-012 SHALL have port err, output, 1: sticky flag set on any mismatch.
REQ-013 SHALL have port halted, output, 1: high while in state HALT.
REQ-014 SHALL have ports ff_a, ff_b (WIDTH) and ff_sum, ff_exp (WIDTH+1), output: first-failure record.
REQ-015 SHALL have port chk_valid, output, 1: one-cycle pulse per completed comparison.

Function
REQ-016 A sample SHALL be accepted on a cycle with in_valid && in_ready.
REQ-017 Stage 1 SHALL register a, b and sum on acceptance, and SHALL compute exp = zero-extended a + zero-extended b at WIDTH+1 bits with no truncation.
REQ-018 Stage 2 SHALL compare the registered sum with exp one cycle after acceptance, and SHALL pulse chk_valid; total latency from acceptance to counter update is 2 cycles.
REQ-019 FSM states SHALL be IDLE, RUN and HALT, with these transitions:
- IDLE -> RUN on the first acceptance.
- RUN -> HALT on a stage-2 mismatch when HALT_ON_FAIL=1.
- HALT -> IDLE on clear.
- RUN -> IDLE when no sample arrives for 1 cycle and the pipeline is empty.
REQ-020 in_ready SHALL be 1 in IDLE and RUN, and 0 in HALT and during the reset cycle.
REQ-021 After a mismatch with HALT_ON_FAIL=1, a sample accepted in the same cycle as the mismatch SHALL still be checked and counted; no sample SHALL be accepted after that.
REQ-022 On a match, pass_cnt SHALL increment; on a mismatch, fail_cnt SHALL increment and err SHALL be set.
REQ-023 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 The ff_* registers SHALL load only on the first mismatch after reset or clear, and SHALL hold on later mismatches.
REQ-025 When clear and a stage-2 result occur in the same cycle, clear SHALL win: counters and flags read 0 the next cycle and the in-flight result is discarded.
REQ-026 When clear and acceptance occur in the same cycle, the accepted sample SHALL proceed normally and be counted after the clear.
REQ-027 Back-to-back samples SHALL be accepted at 1 per cycle with no bubbles in RUN.

Reset
REQ-028 On rst, the next state SHALL be IDLE.
REQ-029 On rst, pass_cnt, fail_cnt, err, halted, chk_valid and all ff_* outputs SHALL be 0.
REQ-030 On rst, the pipeline valid bits SHALL be cleared.
REQ-031 A reset asserted mid-pipeline SHALL discard in-flight samples without counting them.
REQ-032 in_ready SHALL be 0 in the cycle rst is high and 1 in the cycle after.

Structure
REQ-033 Package cla_pkg SHALL hold the state enum (IDLE, RUN, HALT), the default WIDTH and CNT_W constants, and a packed struct {a, b, sum} sample type.
REQ-034 One sub-module, sat_counter (CNT_W, inc, clr), SHALL be instantiated twice, once for passes and once for fails.
REQ-035 The expected-sum adder SHALL be behavioral; it SHALL NOT instantiate the CLA under test.

Verification
REQ-036 Reset, then stream (2,7,9), (4,12,16), (13,10,23): pass_cnt=3, fail_cnt=0, err=0, chk_valid pulses 2 cycles after each accept.
REQ-037 Apply (9,8,16), a wrong sum, with HALT_ON_FAIL=1: fail_cnt=1, err=1, ff_a=9, ff_b=8, ff_sum=16, ff_exp=17, halted=1, in_ready=0.
REQ-038 Apply (5,5,10) then (1,6,6) back-to-back, then (5,3,9): first-failure record holds (1,6,6,7), and the third sample is never accepted.
REQ-039 Force pass_cnt to 0xFFFE, apply 3 correct samples: pass_cnt stays at 0xFFFF.
REQ-040 Assert clear in the same cycle as a stage-2 mismatch: counters read 0, err=0, state returns to IDLE.
REQ-041 Assert rst one cycle after accepting (15,15,30): no count change, all outputs 0, in_ready=1 on the following cycle.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and defaults for the CLA result checker.
// The sample struct matches the default operand width.
package cla_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic [WIDTH_DEF:0]   sum;
  } sample_t;

endpackage

// File: rtl/cla_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign cnt = count;

endmodule

// File: rtl/cla_checker.sv
// Two-stage checker comparing an adder's result against a
// behavioral reference sum, with counters and first-failure capture.
module cla_checker
  import cla_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter bit HALT_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             halted,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH:0]   ff_sum,
  output logic [WIDTH:0]   ff_exp,
  output logic             chk_valid
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   exp;
  } stage_t;

  state_t state;
  stage_t s1;
  logic   s1_valid;
  logic   accept;
  logic   match;
  logic   mismatch;

  assign in_ready = !rst && (state != HALT);
  assign accept   = in_valid && in_ready;
  assign match    = s1_valid && (s1.sum == s1.exp);
  assign mismatch = s1_valid && (s1.sum != s1.exp);
  assign halted   = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s1        <= '0;
      s1_valid  <= 1'b0;
      chk_valid <= 1'b0;
      err       <= 1'b0;
      ff_a      <= '0;
      ff_b      <= '0;
      ff_sum    <= '0;
      ff_exp    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1.a   <= a;
        s1.b   <= b;
        s1.sum <= sum;
        s1.exp <= {1'b0, a} + {1'b0, b};
      end
      // a clear in the compare cycle drops that result entirely
      chk_valid <= s1_valid && !clear;
      if (clear) begin
        err    <= 1'b0;
        ff_a   <= '0;
        ff_b   <= '0;
        ff_sum <= '0;
        ff_exp <= '0;
        state  <= accept ? RUN : IDLE;
      end else begin
        if (mismatch) begin
          err <= 1'b1;
          if (!err) begin
            ff_a   <= s1.a;
            ff_b   <= s1.b;
            ff_sum <= s1.sum;
            ff_exp <= s1.exp;
          end
        end
        unique case (state)
          IDLE: if (accept) state <= RUN;
          RUN: begin
            if (mismatch && HALT_ON_FAIL)
              state <= HALT;
            else if (!accept && !s1_valid)
              state <= IDLE;
          end
          HALT: state <= HALT;
          default: state <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass (
    .clk (clk),
    .rst (rst),
    .inc (match && !clear),
    .clr (clear),
    .cnt (pass_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail (
    .clk (clk),
    .rst (rst),
    .inc (mismatch && !clear),
    .clr (clear),
    .cnt (fail_cnt)
  );

endmodule

// File: tb/tb_cla_checker.sv
// Scoreboard bench for cla_checker: directed samples push
// expected counter state, a negedge monitor checks each result.
module tb_cla_checker;
  import cla_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic [4:0]  sum = '0;
  logic        in_ready, err, halted, chk_valid;
  logic [15:0] pass_cnt, fail_cnt;
  logic [3:0]  ff_a, ff_b;
  logic [4:0]  ff_sum, ff_exp;

  typedef struct {
    logic [15:0] p;
    logic [15:0] f;
    logic        e;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  exp_t        e_mon;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mp = '0;
  logic [15:0] mf = '0;
  logic        me = 1'b0;

  cla_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .clear     (clear),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .err       (err),
    .halted    (halted),
    .ff_a      (ff_a),
    .ff_b      (ff_b),
    .ff_sum    (ff_sum),
    .ff_exp    (ff_exp),
    .chk_valid (chk_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic sample_t mk(input int x, input int y, input int z);
    sample_t r;
    r.a = 4'(x);
    r.b = 4'(y);
    r.sum = 5'(z);
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_chk: chk_valid=1 at cyc %0d, none due", cyc);
      end else begin
        e_mon = q.pop_front();
        check("latency", cyc, e_mon.stamp + 2);
        check("mon_pass", pass_cnt, e_mon.p);
        check("mon_fail", fail_cnt, e_mon.f);
        check("mon_err", err, e_mon.e);
      end
    end else if (q.size() > 0 && cyc > q[0].stamp + 2) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no chk_valid, got cyc %0d want %0d",
               cyc, q[0].stamp + 2);
      e_mon = q.pop_front();
    end
  end

  task automatic send(input sample_t s, input bit ok,
                      input bit want_acc, input bit track,
                      input bit with_clr);
    logic acc;
    @(negedge clk);
    a = s.a;
    b = s.b;
    sum = s.sum;
    in_valid = 1'b1;
    clear = with_clr;
    #1;
    acc = in_ready;
    check("accept", acc, want_acc);
    if (acc && track) begin
      if (with_clr) begin
        mp = '0;
        mf = '0;
        me = 1'b0;
      end
      if (ok) begin
        if (mp != 16'hFFFF) mp = mp + 16'd1;
      end else begin
        if (mf != 16'hFFFF) mf = mf + 16'd1;
        me = 1'b1;
      end
      q.push_back('{mp, mf, me, cyc});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    mp = '0;
    mf = '0;
    me = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_err", err, 0);
    check("rst_halted", halted, 0);
    check("rst_chk", chk_valid, 0);
    check("rst_ffexp", ff_exp, 0);
    rst = 1'b0;
    #1;
    check("ready_post_rst", in_ready, 1);

    // clean stream
    send(mk(2, 7, 9), 1, 1, 1, 0);
    send(mk(4, 12, 16), 1, 1, 1, 0);
    send(mk(13, 10, 23), 1, 1, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("s1_pass", pass_cnt, 3);
    check("s1_fail", fail_cnt, 0);
    check("s1_err", err, 0);

    // mismatch halts; sample in the mismatch cycle still counts
    send(mk(9, 8, 16), 0, 1, 1, 0);
    send(mk(3, 3, 6), 1, 1, 1, 0);
    send(mk(1, 1, 2), 1, 0, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("h_fail", fail_cnt, 1);
    check("h_pass", pass_cnt, 4);
    check("h_err", err, 1);
    check("h_ffa", ff_a, 9);
    check("h_ffb", ff_b, 8);
    check("h_ffsum", ff_sum, 16);
    check("h_ffexp", ff_exp, 17);
    check("h_halted", halted, 1);
    check("h_ready", in_ready, 0);

    do_clear();
    check("c_pass", pass_cnt, 0);
    check("c_fail", fail_cnt, 0);
    check("c_err", err, 0);
    check("c_halted", halted, 0);
    check("c_ready", in_ready, 1);
    check("c_ffexp", ff_exp, 0);

    // back-to-back pass then fail; later sample refused
    send(mk(5, 5, 10), 1, 1, 1, 0);
    send(mk(1, 6, 6), 0, 1, 1, 0);
    @(posedge clk);
    send(mk(5, 3, 9), 1, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("b_ffa", ff_a, 1);
    check("b_ffb", ff_b, 6);
    check("b_ffsum", ff_sum, 6);
    check("b_ffexp", ff_exp, 7);
    check("b_pass", pass_cnt, 1);
    check("b_fail", fail_cnt, 1);
    check("b_halted", halted, 1);

    // saturation
    do_clear();
    @(negedge clk);
    force dut.u_pass.count = 16'hFFFE;
    #1;
    release dut.u_pass.count;
    mp = 16'hFFFE;
    check("sat_preload", pass_cnt, 16'hFFFE);
    send(mk(1, 2, 3), 1, 1, 1, 0);
    send(mk(7, 7, 14), 1, 1, 1, 0);
    send(mk(15, 1, 16), 1, 1, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("sat_pass", pass_cnt, 16'hFFFF);
    check("sat_fail", fail_cnt, 0);

    // clear collides with a stage-2 mismatch
    send(mk(2, 2, 5), 0, 1, 0, 0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    mp = '0;
    mf = '0;
    me = 1'b0;
    @(negedge clk);
    check("cm_pass", pass_cnt, 0);
    check("cm_fail", fail_cnt, 0);
    check("cm_err", err, 0);
    check("cm_halted", halted, 0);
    check("cm_state", dut.state, IDLE);
    repeat (3) @(posedge clk);

    // clear together with an acceptance
    send(mk(1, 1, 2), 1, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("ca_pre", pass_cnt, 1);
    send(mk(6, 9, 15), 1, 1, 1, 1);
    repeat (4) @(posedge clk);
    #1;
    check("ca_pass", pass_cnt, 1);
    check("ca_fail", fail_cnt, 0);

    // reset while a sample is in flight
    send(mk(15, 15, 30), 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_ready_lo", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    mp = '0;
    mf = '0;
    me = 1'b0;
    #1;
    check("mr_ready_hi", in_ready, 1);
    check("mr_pass", pass_cnt, 0);
    check("mr_fail", fail_cnt, 0);
    check("mr_err", err, 0);
    check("mr_halted", halted, 0);
    check("mr_chk", chk_valid, 0);
    check("mr_ffa", ff_a, 0);
    repeat (4) @(posedge clk);
    #1;
    check("mr_pass_late", pass_cnt, 0);
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
